// File: rtl/fetch_bpred_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_bpred_unit                                              |
// | Purpose  : Fetch-stage PC generator with a tagged, direct-mapped BTB     |
// |            and per-entry saturating direction counters.                  |
// | Options  : BPRED_STATS_EN - builds the lookup/mispredict stat counters   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fetch_bpred_unit #(
  parameter logic [31:0] PC_INIT     = 32'h0,
  parameter int          BTB_ENTRIES = 64,
  parameter int          TAG_BITS    = 8,
  parameter int          CTR_BITS    = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        pc_disable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  input  logic        upd_mispredict,
  output logic [31:0] pc_out,
  output logic [31:0] pcplusfour,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_mispredicts
);

  localparam int                  IDX     = $clog2(BTB_ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);

  // BTB storage: one slot per index, target kept word-aligned (bits [1:0] implied zero)
  logic                valid_q [BTB_ENTRIES];
  logic [TAG_BITS-1:0] tag_q   [BTB_ENTRIES];
  logic [29:0]         tgt_q   [BTB_ENTRIES];
  logic [CTR_BITS-1:0] ctr_q   [BTB_ENTRIES];

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Lookup side, driven from the current fetch PC
  logic [IDX-1:0]      lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic                lk_hit;

  assign lk_idx      = pc_q[IDX+1:2];
  assign lk_tag      = pc_q[IDX+TAG_BITS+1:IDX+2];
  assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = lk_hit && ctr_q[lk_idx][CTR_BITS-1];
  assign pred_target = pred_taken ? {tgt_q[lk_idx], 2'b00} : 32'h0;

  assign pc_out     = pc_q;
  assign pcplusfour = pc_q + 32'd4;

  // Update side, driven from the resolved branch PC
  logic [IDX-1:0]      upd_idx;
  logic [TAG_BITS-1:0] upd_tag;
  logic                upd_hit;

  assign upd_idx = upd_pc[IDX+1:2];
  assign upd_tag = upd_pc[IDX+TAG_BITS+1:IDX+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Next-PC selection: redirect beats everything, stall/miss holds the PC
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (ihit && !pc_disable) begin
      pc_d = pred_taken ? pred_target : pcplusfour;
    end
  end

  // Fetch PC register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_q <= PC_INIT;
    end else begin
      pc_q <= pc_d;
    end
  end

  // BTB training: hysteresis on hits, allocate only on a taken miss
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          if (ctr_q[upd_idx] != CTR_MAX) begin
            ctr_q[upd_idx] <= ctr_q[upd_idx] + CTR_ONE;
          end
          tgt_q[upd_idx] <= upd_target[31:2];
        end else if (ctr_q[upd_idx] != '0) begin
          ctr_q[upd_idx] <= ctr_q[upd_idx] - CTR_ONE;
        end
      end else if (upd_taken) begin
        valid_q[upd_idx] <= 1'b1;
        tag_q[upd_idx]   <= upd_tag;
        tgt_q[upd_idx]   <= upd_target[31:2];
        ctr_q[upd_idx]   <= CTR_WT;
      end
    end
  end

`ifdef BPRED_STATS_EN
  logic [31:0] stat_lookups_q;
  logic [31:0] stat_mispredicts_q;

  // Saturating event counters for predicted-taken fetches and mispredicts
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_lookups_q     <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      if (ihit && !pc_disable && !redirect_valid && pred_taken &&
          (stat_lookups_q != 32'hFFFF_FFFF)) begin
        stat_lookups_q <= stat_lookups_q + 32'd1;
      end
      if (upd_valid && upd_mispredict && (stat_mispredicts_q != 32'hFFFF_FFFF)) begin
        stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
      end
    end
  end

  assign stat_lookups     = stat_lookups_q;
  assign stat_mispredicts = stat_mispredicts_q;
`else
  assign stat_lookups     = 32'h0;
  assign stat_mispredicts = 32'h0;
`endif

  // Address bits outside index/tag and the mispredict flag (stats off) are not consumed
  logic w_unused;
  assign w_unused = ^{upd_pc, upd_target[1:0], upd_mispredict};

endmodule
`default_nettype wire

// File: tb/tb_fetch_bpred_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fetch_bpred_unit                                           |
// | Purpose  : Scoreboard bench for fetch_bpred_unit against a behavioural   |
// |            BTB model (follows BPRED_STATS_EN like the design).           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fetch_bpred_unit;

  localparam logic [31:0] PCI   = 32'h100;
  localparam int          ENT   = 64;
  localparam int          TAGB  = 8;
  localparam int          CTRB  = 2;
  localparam int          CMAX  = (1 << CTRB) - 1;
  localparam int          CHALF = 1 << (CTRB - 1);

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit, pc_disable, redirect_valid, upd_valid, upd_taken, upd_mispredict;
  logic [31:0] redirect_pc, upd_pc, upd_target;
  logic [31:0] pc_out, pcplusfour, pred_target, stat_lookups, stat_mispredicts;
  logic        pred_taken;

  fetch_bpred_unit #(
    .PC_INIT(PCI), .BTB_ENTRIES(ENT), .TAG_BITS(TAGB), .CTR_BITS(CTRB)
  ) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .pc_disable(pc_disable),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .pc_out(pc_out), .pcplusfour(pcplusfour), .pred_taken(pred_taken),
    .pred_target(pred_target), .stat_lookups(stat_lookups),
    .stat_mispredicts(stat_mispredicts)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] p4;
    logic        pt;
    logic [31:0] tgt;
    logic [31:0] sl;
    logic [31:0] sm;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_mis = 0;

  // Behavioural model: array of entries, integer counters
  logic [31:0] m_pc, m_sl, m_sm;
  bit          m_vld [ENT];
  int unsigned m_tag [ENT];
  logic [31:0] m_tgt [ENT];
  int          m_ctr [ENT];

  function automatic int unsigned idx_of(input logic [31:0] a);
    return (a / 4) % ENT;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    return (a / (4 * ENT)) % (1 << TAGB);
  endfunction

  function automatic bit m_pred(input logic [31:0] a);
    int unsigned i = idx_of(a);
    return m_vld[i] && (m_tag[i] == tag_of(a)) && (m_ctr[i] >= CHALF);
  endfunction

  function automatic logic [31:0] m_ptgt(input logic [31:0] a);
    return m_pred(a) ? m_tgt[idx_of(a)] : 32'h0;
  endfunction

  task automatic model_reset();
    m_pc = PCI;
    m_sl = 0;
    m_sm = 0;
    for (int i = 0; i < ENT; i++) begin
      m_vld[i] = 1'b0;
      m_tag[i] = 0;
      m_tgt[i] = 32'h0;
      m_ctr[i] = CHALF - 1;
    end
  endtask

  task automatic clear_inputs();
    ihit = 0; pc_disable = 0; redirect_valid = 0; redirect_pc = 0;
    upd_valid = 0; upd_pc = 0; upd_target = 0; upd_taken = 0; upd_mispredict = 0;
  endtask

  // One clock of stimulus; the post-edge expectation goes onto the scoreboard
  task automatic step(input bit ih, input bit dis, input bit rv, input logic [31:0] rpc,
                      input bit uv, input logic [31:0] upc, input logic [31:0] utg,
                      input bit utk, input bit umis);
    exp_t        e;
    bit          pt;
    logic [31:0] nxt;
    int unsigned ui;
    @(negedge CLK);
    ihit = ih; pc_disable = dis; redirect_valid = rv; redirect_pc = rpc;
    upd_valid = uv; upd_pc = upc; upd_target = utg; upd_taken = utk; upd_mispredict = umis;
    pt = m_pred(m_pc);
    if (rv) nxt = rpc;
    else if (ih && !dis && pt) nxt = m_ptgt(m_pc);
    else if (ih && !dis) nxt = m_pc + 32'd4;
    else nxt = m_pc;
`ifdef BPRED_STATS_EN
    if (ih && !dis && !rv && pt && m_sl != 32'hFFFF_FFFF) m_sl = m_sl + 1;
    if (uv && umis && m_sm != 32'hFFFF_FFFF) m_sm = m_sm + 1;
`endif
    if (uv) begin
      ui = idx_of(upc);
      if (m_vld[ui] && m_tag[ui] == tag_of(upc)) begin
        if (utk) begin
          m_ctr[ui] = (m_ctr[ui] < CMAX) ? m_ctr[ui] + 1 : CMAX;
          m_tgt[ui] = {utg[31:2], 2'b00};
        end else begin
          m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
        end
      end else if (utk) begin
        m_vld[ui] = 1'b1;
        m_tag[ui] = tag_of(upc);
        m_tgt[ui] = {utg[31:2], 2'b00};
        m_ctr[ui] = CHALF;
      end
    end
    m_pc  = nxt;
    e.pc  = m_pc;
    e.p4  = m_pc + 32'd4;
    e.pt  = m_pred(m_pc);
    e.tgt = m_ptgt(m_pc);
    e.sl  = m_sl;
    e.sm  = m_sm;
    sbq.push_back(e);
  endtask

  task automatic fetch();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic redir(input logic [31:0] a);
    step(0, 0, 1, a, 0, 0, 0, 0, 0);
  endtask

  task automatic upd(input logic [31:0] p, input logic [31:0] t, input bit tk, input bit mis);
    step(0, 0, 0, 0, 1, p, t, tk, mis);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Let the last step be consumed, park inputs, and make sure the scoreboard empties
  task automatic drain();
    @(negedge CLK);
    clear_inputs();
    for (int k = 0; k < 20 && sbq.size() != 0; k++) @(posedge CLK);
    if (sbq.size() != 0) begin
      n_vec++;
      n_mis++;
      $display("FAIL drain: %0d entries left, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  function automatic logic [31:0] pool();
    return 32'h100 + 32'(4 * $urandom_range(0, 255));
  endfunction

  // Monitor: the DUT presents a new fetch state after every edge
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        n_vec++;
        if (pc_out !== e.pc || pcplusfour !== e.p4 || pred_taken !== e.pt ||
            pred_target !== e.tgt || stat_lookups !== e.sl || stat_mispredicts !== e.sm) begin
          n_mis++;
          $display("FAIL fetch-state @%0t: pc=%h p4=%h pt=%b tgt=%h sl=%0d sm=%0d, required pc=%h p4=%h pt=%b tgt=%h sl=%0d sm=%0d",
                   $time, pc_out, pcplusfour, pred_taken, pred_target, stat_lookups, stat_mispredicts,
                   e.pc, e.p4, e.pt, e.tgt, e.sl, e.sm);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin : driver
    clear_inputs();
    model_reset();
    repeat (2) @(negedge CLK);
    chk("reset_pc", pc_out, PCI);
    chk("reset_pcplusfour", pcplusfour, PCI + 32'd4);
    chk("reset_pred_taken", {31'h0, pred_taken}, 32'h0);
    chk("reset_pred_target", pred_target, 32'h0);
    chk("reset_stat_lookups", stat_lookups, 32'h0);
    chk("reset_stat_mispredicts", stat_mispredicts, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;

    // Sequential fetch 0x100 -> 0x10C
    repeat (3) fetch();
    // Allocate 0x10C -> 0x200 while stalled at 0x10C, then follow the prediction
    upd(32'h10C, 32'h200, 1, 0);
    fetch();
    // Two not-taken updates drop below threshold, third saturates at 0
    redir(32'h10C);
    upd(32'h10C, 32'h200, 0, 1);
    upd(32'h10C, 32'h200, 0, 1);
    upd(32'h10C, 32'h200, 0, 0);
    upd(32'h10C, 32'h200, 1, 0);
    fetch();
    // Retrain to taken, then alias at 0x20C
    redir(32'h10C);
    upd(32'h10C, 32'h200, 1, 0);
    redir(32'h20C);
    fetch();
    // Redirect wins over stall/ihit=0 while predicting taken; stall holds
    redir(32'h10C);
    step(0, 1, 1, 32'h400, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Five predicted-taken fetches
    for (int n = 0; n < 5; n++) begin
      redir(32'h10C);
      fetch();
    end
    // Redirect during a predicted-taken fetch, with a concurrent update
    redir(32'h10C);
    step(1, 0, 1, 32'h300, 1, 32'h300, 32'h500, 1, 1);
    // PC wraps modulo 2^32
    redir(32'hFFFF_FFFC);
    fetch();
    drain();

    // Asynchronous reset mid-operation, away from any clock edge
    redir(32'h10C);
    drain();
    #2;
    nRST = 1'b0;
    #1;
    chk("midreset_pc", pc_out, PCI);
    chk("midreset_pred_taken", {31'h0, pred_taken}, 32'h0);
    chk("midreset_stat_lookups", stat_lookups, 32'h0);
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
    redir(32'h10C);

    // Randomized traffic over a 1 KB window (four tags per index)
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 6) == 0, pool(),
           $urandom_range(0, 2) != 0, ($urandom_range(0, 3) == 0) ? m_pc : pool(),
           ($urandom_range(0, 9) == 0) ? ($urandom() & 32'hFFFF_FFFC) : pool(),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_bpred_unit.md
Name: fetch_bpred_unit

Overview:
- Parametrised fetch-stage PC generator with a tagged, direct-mapped branch target buffer (BTB) and per-entry saturating direction counters.
- Successor to the single-bit, untagged fetch BTB. Adds configurable depth, tag match, hysteresis counters and an explicit redirect port.
- Sits between the hazard unit / mem-stage branch resolution and the icache request port.

Parameters:
- PC_INIT, 32'h0, PC value loaded on reset.
- BTB_ENTRIES, 64, number of BTB entries; must be a power of two, at least 2.
- TAG_BITS, 8, tag width stored per entry; TAG_BITS + log2(BTB_ENTRIES) + 2 must be at most 32.
- CTR_BITS, 2, width of the saturating direction counter; at least 1.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- ihit  in  1  icache returned the instruction at pc_out this cycle.
- pc_disable  in  1  hazard stall; blocks sequential and predicted advance.
- redirect_valid  in  1  mem stage or hazard unit forces the next PC.
- redirect_pc  in  32  forced next PC (branch target, jr, j, or resolved pc+4).
- upd_valid  in  1  a branch resolved in mem this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_target  in  32  computed branch target.
- upd_taken  in  1  actual branch outcome.
- upd_mispredict  in  1  prediction made for upd_pc was wrong (statistics only).
- pc_out  out  32  current fetch PC.
- pcplusfour  out  32  pc_out + 4.
- pred_taken  out  1  BTB hit and counter predicts taken for pc_out.
- pred_target  out  32  predicted target; valid when pred_taken = 1.
- stat_lookups  out  32  predicted-taken fetch count (optional feature).
- stat_mispredicts  out  32  mispredict count (optional feature).

Behaviour:
- Index and tag:
  - IDX = log2(BTB_ENTRIES).
  - index = pc[IDX+1:2].
  - tag = pc[IDX+TAG_BITS+1:IDX+2].
- Entry contents: valid, tag, target[31:2], counter. Bits [1:0] of any target are always 0.
- Reset (asynchronous):
  - pc_out = PC_INIT.
  - All entries valid = 0, counters = 2^(CTR_BITS-1) - 1 (weakly not-taken).
  - pred_taken = 0, stat counters = 0.
- Lookup is combinational on pc_out: hit = valid && tag match; pred_taken = hit && counter MSB. pred_target = {stored target, 2'b00} when pred_taken, else 0.
- next_pc priority, registered on the rising edge:
  1. redirect_valid = 1: next_pc = redirect_pc. Applies regardless of ihit or pc_disable.
  2. ihit && !pc_disable && pred_taken: next_pc = pred_target.
  3. ihit && !pc_disable: next_pc = pc_out + 4, wrapping modulo 2^32.
  4. Otherwise: pc_out holds.
- Update, registered on the edge, when upd_valid = 1:
  - Entry hit (valid and tag match for upd_pc):
    - Counter increments if upd_taken, decrements otherwise, saturating at 0 and 2^CTR_BITS - 1.
    - Target is rewritten only when upd_taken.
  - Entry miss, upd_taken = 1: allocate by overwriting the entry. valid = 1, tag and target from the update, counter = 2^(CTR_BITS-1) (weakly taken).
  - Entry miss, upd_taken = 0: no change to the entry.
- Same-cycle lookup and update to the same index: lookup sees pre-update contents. No bypass.
- Update and redirect arriving together are independent; both take effect on the same edge.
- Reset asserted mid-operation clears all state immediately. Nothing persists past reset.

Optional Feature:
- Macro: BPRED_STATS_EN.
- Defined:
  - stat_lookups increments on every edge where ihit && !pc_disable && !redirect_valid && pred_taken.
  - stat_mispredicts increments on every edge where upd_valid && upd_mispredict.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: no counter registers are built; both outputs are tied to 0.

Test Plan:
- Reset with PC_INIT = 32'h100, then ihit = 1 for 3 cycles -> pc_out sequence 0x100, 0x104, 0x108, 0x10C; pred_taken = 0 throughout.
- upd_valid with upd_pc = 0x10C, upd_target = 0x200, upd_taken = 1, then fetch reaches 0x10C with ihit = 1 -> pred_taken = 1, pred_target = 0x200, next pc_out = 0x200.
- Same entry updated not-taken twice, counter 10 -> 01 -> 00 -> pred_taken = 0 at 0x10C; a third not-taken leaves counter at 00 (saturation).
- Aliasing: with the 0x10C entry allocated and BTB_ENTRIES = 64, fetch PC 0x20C (same index, different tag) -> pred_taken = 0, next pc_out = 0x210.
- Simultaneous events: redirect_valid = 1 with redirect_pc = 0x400 while pc_disable = 1, ihit = 0, and pred_taken = 1 -> pc_out = 0x400 next cycle. Stall without redirect holds pc_out.
- BPRED_STATS_EN defined, 5 predicted-taken fetches and 2 mispredict updates -> stat_lookups = 5, stat_mispredicts = 2; with the macro undefined, both read 0.
